// File: rtl/dbus_interconnect.sv
// rtl/dbus_interconnect.sv - CPU data-bus address decoder with read wait states and bus-error capture
module dbus_interconnect #(
  parameter int                        NSLAVES = 4,
  parameter int                        ADDRW   = 16,
  parameter int                        DATAW   = 16,
  parameter logic [NSLAVES*ADDRW-1:0]  BASE    = {16'h8000, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [NSLAVES*ADDRW-1:0]  SIZE    = {16'h4000, 16'h4000, 16'h2000, 16'h2000},
  parameter logic [2*NSLAVES-1:0]      WAIT    = 8'b10_01_00_00,
  parameter logic [DATAW-1:0]          ERRDATA = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dread_req,
  input  logic [ADDRW-1:0]           dread_addr,
  input  logic [ADDRW-1:0]           dwrite_addr,
  input  logic [1:0]                 dwrite_en,
  output logic [2*NSLAVES-1:0]       slv_dwrite_en,
  input  logic [DATAW*NSLAVES-1:0]   slv_dread_data,
  output logic [DATAW-1:0]           dread_data,
  output logic                       dread_valid,
  output logic                       stall,
  output logic                       bus_error,
  output logic                       err_flag,
  output logic [ADDRW-1:0]           err_addr,
  input  logic                       err_clear
);

  localparam int SELW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

  state_t            r_state, w_state_next;
  logic [1:0]        r_cnt, w_cnt_next;
  logic [SELW-1:0]   r_sel, w_sel_next;
  logic              r_unmapped, w_unmapped_next;
  logic              r_bus_error;
  logic              r_err_flag;
  logic [ADDRW-1:0]  r_err_addr;

  logic [SELW:0]     w_rd_dec, w_wr_dec;
  logic              w_rd_hit, w_wr_hit;
  logic [SELW-1:0]   w_rd_sel, w_wr_sel;
  logic [1:0]        w_rd_wait;
  logic              w_rd_accept;
  logic              w_rd_err, w_wr_err;
  logic [2*NSLAVES-1:0] w_slv_we;
  logic [DATAW-1:0]  w_rdata;

  // Returns {hit, sel}; bounds widened by one bit so a region ending at 2^ADDRW does not wrap.
  function automatic logic [SELW:0] decode(input logic [ADDRW-1:0] addr);
    logic [ADDRW:0] a, lo, hi;
    logic [SELW:0]  res;
    res = '0;
    a   = {1'b0, addr};
    for (int i = 0; i < NSLAVES; i++) begin
      lo = {1'b0, BASE[i*ADDRW +: ADDRW]};
      hi = lo + {1'b0, SIZE[i*ADDRW +: ADDRW]};
      if (!res[SELW] && a >= lo && a < hi) res = {1'b1, SELW'(i)};
    end
    return res;
  endfunction

  assign w_rd_dec = decode(dread_addr);
  assign w_wr_dec = decode(dwrite_addr);
  assign w_rd_hit = w_rd_dec[SELW];
  assign w_rd_sel = w_rd_dec[SELW-1:0];
  assign w_wr_hit = w_wr_dec[SELW];
  assign w_wr_sel = w_wr_dec[SELW-1:0];

  // Extra read wait states of the slave addressed by the incoming read; unmapped reads take none.
  always_comb begin
    w_rd_wait = 2'd0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (w_rd_hit && w_rd_sel == SELW'(i)) w_rd_wait = WAIT[2*i +: 2];
    end
  end

  // Write byte-enables steered to the addressed slave only, held off during reset.
  always_comb begin
    w_slv_we = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!reset && w_wr_hit && w_wr_sel == SELW'(i)) w_slv_we[2*i +: 2] = dwrite_en;
    end
  end

  // Read FSM next-state: a request is taken in IDLE or DATA, never while waiting.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_sel_next      = r_sel;
    w_unmapped_next = r_unmapped;
    w_rd_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DATA: begin
        if (dread_req) begin
          w_rd_accept     = 1'b1;
          w_sel_next      = w_rd_sel;
          w_unmapped_next = !w_rd_hit;
          w_cnt_next      = w_rd_wait;
          w_state_next    = (w_rd_wait == 2'd0) ? S_DATA : S_WAIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 2'd1;
        if (r_cnt <= 2'd1) w_state_next = S_DATA;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read FSM state, selected slave and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_sel      <= '0;
      r_unmapped <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_sel      <= w_sel_next;
      r_unmapped <= w_unmapped_next;
    end
  end

  // An unmapped read errors in its DATA cycle; an unmapped write errors one cycle later.
  assign w_rd_err = w_rd_accept && !w_rd_hit;
  assign w_wr_err = !w_wr_hit && (dwrite_en != 2'b00);

  // Error pulse, sticky flag and faulting address; the read address wins a simultaneous fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_error <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_bus_error <= w_rd_err || w_wr_err;
      if (w_rd_err)      r_err_addr <= dread_addr;
      else if (w_wr_err) r_err_addr <= dwrite_addr;
      if (w_rd_err || w_wr_err) r_err_flag <= 1'b1;
      else if (err_clear)       r_err_flag <= 1'b0;
    end
  end

  // Read data steered from the registered selection, zero outside the DATA cycle.
  always_comb begin
    w_rdata = '0;
    if (r_state == S_DATA) begin
      if (r_unmapped) begin
        w_rdata = ERRDATA;
      end else begin
        for (int i = 0; i < NSLAVES; i++) begin
          if (r_sel == SELW'(i)) w_rdata = slv_dread_data[DATAW*i +: DATAW];
        end
      end
    end
  end

  assign slv_dwrite_en = w_slv_we;
  assign dread_data    = w_rdata;
  assign dread_valid   = (r_state == S_DATA);
  assign stall         = (r_state == S_WAIT);
  assign bus_error     = r_bus_error;
  assign err_flag      = r_err_flag;
  assign err_addr      = r_err_addr;

endmodule
